// File: rtl/lift_input_buffer_ctrl.sv
// lift_input_buffer_ctrl: sequences writes of 240-bit beats into the lift input
// buffer and drains the stored words as a serial 30-bit coefficient stream.
// Optional two-bank ping-pong operation: define LIFT_IN_CTRL_PINGPONG_EN.
module lift_input_buffer_ctrl #(
  parameter int unsigned WORDS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        buf_we,
  output logic [5:0]  buf_write_address,
  output logic [5:0]  buf_read_address,
  output logic [2:0]  buf_read_sel,
  input  logic [29:0] buf_read_data,
  output logic [29:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy
);

  localparam int unsigned AW  = 6;
  localparam int unsigned SW  = 3;
  localparam int unsigned RCW = AW + SW;
  localparam int unsigned DW  = 30;
  localparam int unsigned FD  = 3;
  localparam int unsigned CW  = 2;
  localparam int unsigned OCW = CW + 1;
  localparam logic [AW-1:0]  LAST_WORD = AW'(WORDS - 1);
  localparam logic [RCW-1:0] LAST_COEF = RCW'(8 * WORDS - 1);

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } fifo_entry_t;

  // Reject word counts the buffer cannot hold in the selected mode
`ifdef LIFT_IN_CTRL_PINGPONG_EN
  if (WORDS < 1 || WORDS > 32) begin : g_words_range
    $error("lift_input_buffer_ctrl: WORDS must be 1..32 with ping-pong banking");
  end
`else
  if (WORDS < 1 || WORDS > 64) begin : g_words_range
    $error("lift_input_buffer_ctrl: WORDS must be 1..64");
  end
`endif

  logic           started_q;
  logic [AW-1:0]  wc_q;
  logic [RCW-1:0] rc_q;
  logic           inflight_q;
  logic           inflight_last_q;
  logic [SW-1:0]  sel_q;
  fifo_entry_t    fifo_q [FD];
  fifo_entry_t    fifo_d [FD];
  logic [CW-1:0]  count_q;
  logic [CW-1:0]  count_d;
  logic [CW-1:0]  wr_idx;

  logic accept;
  logic wr_done;
  logic pop;
  logic last_pop;
  logic rd_ok;
  logic room;
  logic issue;
  logic rd_wrap;
  logic any_full;

  assign accept   = in_valid & in_ready;
  assign buf_we   = accept;
  assign wr_done  = accept & (wc_q == LAST_WORD);

  assign out_valid = (count_q != '0);
  assign out_data  = fifo_q[0].data;
  assign out_last  = out_valid & fifo_q[0].last;
  assign pop       = out_valid & out_ready;
  assign last_pop  = pop & fifo_q[0].last;

  // Queued plus in-flight words may never exceed the FIFO depth
  assign room    = ({1'b0, count_q} + OCW'(inflight_q)) < OCW'(FD);
  assign issue   = rd_ok & room;
  assign rd_wrap = issue & (rc_q == LAST_COEF);

  assign buf_read_sel = sel_q;
  assign busy         = any_full | (wc_q != '0) | inflight_q | out_valid;

`ifdef LIFT_IN_CTRL_PINGPONG_EN
  logic [1:0] full_q;
  logic [1:0] full_d;
  logic       wb_q;
  logic       rb_q;
  logic       db_q;

  // Per-bank full flags: fill and release of opposite banks may coincide
  always_comb begin
    full_d = full_q;
    if (wr_done) begin
      full_d[wb_q] = 1'b1;
    end
    if (last_pop) begin
      full_d[db_q] = 1'b0;
    end
  end

  // Bank pointers: write, read-issue and pop side each advance on completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= '0;
      wb_q   <= 1'b0;
      rb_q   <= 1'b0;
      db_q   <= 1'b0;
    end else begin
      full_q <= full_d;
      if (wr_done) begin
        wb_q <= ~wb_q;
      end
      if (rd_wrap) begin
        rb_q <= ~rb_q;
      end
      if (last_pop) begin
        db_q <= ~db_q;
      end
    end
  end

  assign rd_ok             = full_q[rb_q];
  assign any_full          = |full_q;
  assign in_ready          = started_q & ~full_q[wb_q];
  assign buf_write_address = {wb_q, wc_q[AW-2:0]};
  assign buf_read_address  = {rb_q, rc_q[RCW-2:SW]};
`else
  typedef enum logic [0:0] {
    ST_LOAD  = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   rd_done_q;

  // Single bank alternates between loading and draining
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    unique case (state_q)
      ST_LOAD: begin
        in_ready = started_q;
        if (wr_done) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (last_pop) begin
          state_d = ST_LOAD;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // State register plus flag that stops issue once the final read went out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_LOAD;
      rd_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (rd_wrap) begin
        rd_done_q <= 1'b1;
      end else if (last_pop) begin
        rd_done_q <= 1'b0;
      end
    end
  end

  assign rd_ok             = (state_q == ST_DRAIN) & ~rd_done_q;
  assign any_full          = (state_q == ST_DRAIN);
  assign buf_write_address = wc_q;
  assign buf_read_address  = rc_q[RCW-1:SW];
`endif

  // Enable in_ready one clock after reset release; write word counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started_q <= 1'b0;
      wc_q      <= '0;
    end else begin
      started_q <= 1'b1;
      if (accept) begin
        wc_q <= wr_done ? '0 : wc_q + AW'(1);
      end
    end
  end

  // Read counter and one-cycle in-flight tracking for the registered RAM port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rc_q            <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      sel_q           <= '0;
    end else begin
      inflight_q      <= issue;
      inflight_last_q <= rd_wrap;
      if (issue) begin
        rc_q  <= rd_wrap ? '0 : rc_q + RCW'(1);
        sel_q <= rc_q[SW-1:0];
      end
    end
  end

  // Output FIFO next state: shift on pop, append returning word behind the tail
  always_comb begin
    for (int i = 0; i < int'(FD); i++) begin
      fifo_d[i] = fifo_q[i];
    end
    count_d = count_q;
    wr_idx  = count_q;
    if (pop) begin
      for (int i = 0; i < int'(FD) - 1; i++) begin
        fifo_d[i] = fifo_q[i + 1];
      end
      fifo_d[FD-1] = '0;
      count_d      = count_q - CW'(1);
      wr_idx       = count_q - CW'(1);
    end
    if (inflight_q) begin
      fifo_d[wr_idx].last = inflight_last_q;
      fifo_d[wr_idx].data = buf_read_data;
      count_d             = count_d + CW'(1);
    end
  end

  // Output FIFO storage; head entry drives the coefficient outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(FD); i++) begin
        fifo_q[i] <= '0;
      end
      count_q <= '0;
    end else begin
      for (int i = 0; i < int'(FD); i++) begin
        fifo_q[i] <= fifo_d[i];
      end
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_lift_input_buffer_ctrl.sv
// tb_lift_input_buffer_ctrl: randomized bench with a queue-based reference model
// of the coefficient stream and a behavioural model of the lift input buffer.
`timescale 1ns/1ps
module tb_lift_input_buffer_ctrl;

  localparam int unsigned W  = 4;
`ifdef LIFT_IN_CTRL_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [239:0] din = '0;
  logic         in_ready;
  logic         buf_we;
  logic [5:0]   buf_write_address;
  logic [5:0]   buf_read_address;
  logic [2:0]   buf_read_sel;
  logic [29:0]  buf_read_data;
  logic [29:0]  out_data;
  logic         out_valid;
  logic         out_last;
  logic         busy;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  lift_input_buffer_ctrl #(.WORDS(W)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .buf_we            (buf_we),
    .buf_write_address (buf_write_address),
    .buf_read_address  (buf_read_address),
    .buf_read_sel      (buf_read_sel),
    .buf_read_data     (buf_read_data),
    .out_data          (out_data),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_last          (out_last),
    .busy              (busy)
  );

  // Buffer model: 64 words of 8 lanes, registered read, lane mux after the register
  logic [239:0] ram [64];
  logic [239:0] rd_word = '0;
  always @(posedge clk) begin
    if (buf_we) ram[buf_write_address] <= din;
    rd_word <= ram[buf_read_address];
  end
  assign buf_read_data = rd_word[30*buf_read_sel +: 30];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model state: polynomial bookkeeping and the expected stream
  logic [30:0] expq[$];
  int  cyc = 0;
  int  acc_in_poly = 0;
  int  loaded = 0;
  int  done = 0;
  int  pops_in_poly = 0;
  int  lat_cyc = 0;
  bit  started_m = 1'b0;
  bit  lat_arm = 1'b0;
  bit  hold_v = 1'b0;
  bit  exp_rdy;
  logic [30:0] hold_d;
  logic [30:0] e;

  // Compare process: checks every cycle, then advances the model past the next edge
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      expq.delete();
      acc_in_poly = 0; loaded = 0; done = 0; pops_in_poly = 0;
      started_m = 1'b0; lat_arm = 1'b0; hold_v = 1'b0;
    end else begin
      exp_rdy = started_m && ((loaded - done) < (PP ? 2 : 1));
      chk("in_ready", 64'(in_ready), 64'(exp_rdy));
      chk("buf_we", 64'(buf_we), 64'(in_valid && exp_rdy));
      chk("wr_addr", 64'(buf_write_address), 64'(acc_in_poly + (PP ? 32 * (loaded % 2) : 0)));
      chk("busy", 64'(busy), 64'((acc_in_poly != 0) || (loaded > done)));
      if (hold_v) begin
        chk("hold_valid", 64'(out_valid), 64'(1));
        chk("hold_data", 64'({out_last, out_data}), 64'(hold_d));
      end
      hold_v = out_valid && !out_ready;
      hold_d = {out_last, out_data};
      if (lat_arm) begin
        if (cyc == lat_cyc + 2) chk("lat_t2", 64'(out_valid), 64'(0));
        if (cyc == lat_cyc + 3) begin
          chk("lat_t3", 64'(out_valid), 64'(1));
          lat_arm = 1'b0;
        end
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          total++; bad++;
          $display("FAIL coef: got %0h expected none (stream empty) at %0t", out_data, $time);
        end else begin
          e = expq.pop_front();
          chk("coef", 64'({out_last, out_data}), 64'(e));
          pops_in_poly++;
          if (e[30]) begin
            done++;
            pops_in_poly = 0;
          end
        end
      end
      if (in_valid && exp_rdy) begin
        for (int l = 0; l < 8; l++)
          expq.push_back({(l == 7) && (acc_in_poly == int'(W) - 1), din[30*l +: 30]});
        if (acc_in_poly == int'(W) - 1) begin
          if (loaded == done) begin
            lat_arm = 1'b1;
            lat_cyc = cyc;
          end
          loaded++;
          acc_in_poly = 0;
        end else begin
          acc_in_poly++;
        end
      end
      started_m = 1'b1;
    end
  end

  task automatic tick(input bit v, input bit r);
    @(posedge clk);
    #1;
    in_valid  = v;
    out_ready = r;
    for (int l = 0; l < 8; l++) din[30*l +: 30] = 30'($urandom);
  endtask

  task automatic chk_reset_vals();
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_buf_we", 64'(buf_we), 64'(0));
    chk("rst_wr_addr", 64'(buf_write_address), 64'(0));
    chk("rst_rd_addr", 64'(buf_read_address), 64'(0));
    chk("rst_rd_sel", 64'(buf_read_sel), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_last", 64'(out_last), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  int n;
  int lasts;

  initial begin
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals();

    // Release reset; in_ready rises one clock later
    rst_n = 1'b1;
    #1;
    chk("rdy_pre_clock", 64'(in_ready), 64'(0));
    tick(1, 1);
    chk("rdy_first_clock", 64'(in_ready), 64'(1));
    repeat (4) tick(1, 1);
    chk("rdy_after_fill", 64'(in_ready), 64'(PP ? 1 : 0));
    chk("wr_addr_after_fill", 64'(buf_write_address), 64'(PP ? 32 : 0));
    tick(1, 1);
    chk("valid_t2", 64'(out_valid), 64'(0));
    tick(1, 1);
    chk("valid_t3", 64'(out_valid), 64'(1));

    // Sustained one coefficient per cycle through the first polynomial
    n = 0;
    while (out_valid && n < 100) begin
      n++;
      if (out_last) break;
      tick(1, 1);
    end
    chk("burst_len", 64'(n), 64'(8 * W));

    // Random valid/ready traffic
    for (int i = 0; i < 600; i++) tick($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1);

    // Consumer stalled: FIFO fills and issue stops, nothing lost
    for (int i = 0; i < 60; i++) tick(1, 0);
    for (int i = 0; i < 100; i++) tick(1, 1);

    // Reset in the middle of draining after ten coefficients
    n = 0;
    while (pops_in_poly != 10 && n < 300) begin
      tick(1, 1);
      n++;
    end
    chk("reach_ten_pops", 64'(pops_in_poly), 64'(10));
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 120; i++) tick(1, 1);

`ifdef LIFT_IN_CTRL_PINGPONG_EN
    // Gap-free stream across the polynomial boundary with overlapped loading
    n = 0;
    while ((busy || expq.size() != 0) && n < 400) begin
      tick(0, 1);
      n++;
    end
    tick(1, 1);
    n = 0;
    while (!out_valid && n < 20) begin
      tick(1, 1);
      n++;
    end
    n = 0;
    lasts = 0;
    while (out_valid && lasts < 2 && n < 200) begin
      n++;
      if (out_last) lasts++;
      tick(1, 1);
    end
    chk("pingpong_gapfree", 64'(n), 64'(16 * W));
    for (int i = 0; i < 40; i++) tick(1, 0);
    chk("pingpong_stall_rdy", 64'(in_ready), 64'(0));
`endif

    // Final drain: every stored coefficient delivered, controller idle
    n = 0;
    while ((busy || expq.size() != 0) && n < 400) begin
      tick(0, 1);
      n++;
    end
    chk("drain_empty", 64'(expq.size()), 64'(0));
    chk("drain_idle", 64'(busy), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
